// File: rtl/wb_ram_ctrl_if.sv
// wb_ram_ctrl_if: Wishbone B3 bus between an interconnect master and the RAM controller.
interface wb_ram_ctrl_if #(parameter int aw = 32);
    logic [aw-1:0] wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [2:0]    wb_cti_i;
    logic [1:0]    wb_bte_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_ram_ctrl.sv
// wb_ram_ctrl: Wishbone B3 slave driving a 1-cycle-latency byte-write RAM (classic + incrementing bursts).
// Define WB_RAM_CTRL_RANGE_CHECK_EN to err on addresses above depth instead of aliasing.
module wb_ram_ctrl #(
    parameter int depth = 256,
    parameter int aw = 32,
    localparam int lw = $clog2(depth)
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_ram_ctrl_if.slave  wb,
    output logic [3:0]    ram_we,
    output logic [31:0]   ram_din,
    output logic [lw-1:0] ram_waddr,
    output logic [lw-1:0] ram_raddr,
    input  logic [31:0]   ram_dout
);
    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        BURST
`ifdef WB_RAM_CTRL_RANGE_CHECK_EN
        , ERR
`endif
    } state_t;

    state_t        state;
    logic          ack;
    logic          req;
    logic [lw-1:0] word;
    logic [lw-1:0] msk;
    logic [lw-1:0] nxt;
    logic          unused_bits;

    assign req  = wb.wb_cyc_i & wb.wb_stb_i;
    assign word = wb.wb_adr_i[lw+1:2];
    // Wrap bursts keep the upper bits and count only inside the wrap window
    assign msk = wb.wb_bte_i == 2'b01 ? lw'(3) : wb.wb_bte_i == 2'b10 ? lw'(7) : lw'(15);
    assign nxt = wb.wb_bte_i == 2'b00 ? word + 1'b1 : (word & ~msk) | ((word + 1'b1) & msk);
    assign unused_bits = ^{wb.wb_adr_i[1:0], wb.wb_adr_i[aw-1:lw+2]};

    // In a burst the RAM is addressed one beat ahead so data lines up with the next ack
    assign ram_raddr   = state == BURST ? nxt : word;
    assign ram_waddr   = word;
    assign ram_din     = wb.wb_dat_i;
    assign ram_we      = wb.wb_sel_i & {4{ack & req & wb.wb_we_i}};
    assign wb.wb_dat_o = ram_dout;
    assign wb.wb_ack_o = ack;

`ifdef WB_RAM_CTRL_RANGE_CHECK_EN
    logic err;
    logic oor;
    logic nxt_oor;
    assign oor         = |wb.wb_adr_i[aw-1:lw+2];
    assign nxt_oor     = wb.wb_bte_i == 2'b00 && &word;
    assign wb.wb_err_o = err;
`else
    assign wb.wb_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ack   <= 1'b0;
`ifdef WB_RAM_CTRL_RANGE_CHECK_EN
            err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef WB_RAM_CTRL_RANGE_CHECK_EN
                    if (req && oor) begin
                        err   <= 1'b1;
                        state <= ERR;
                    end else
`endif
                    if (req) begin
                        ack   <= 1'b1;
                        state <= wb.wb_cti_i == 3'b010 ? BURST : SINGLE;
                    end
                end
                SINGLE: begin
                    ack   <= 1'b0;
                    state <= IDLE;
                end
                BURST: begin
`ifdef WB_RAM_CTRL_RANGE_CHECK_EN
                    if (wb.wb_cti_i == 3'b111 || !req || nxt_oor) begin
`else
                    if (wb.wb_cti_i == 3'b111 || !req) begin
`endif
                        ack   <= 1'b0;
                        state <= IDLE;
                    end
                end
`ifdef WB_RAM_CTRL_RANGE_CHECK_EN
                ERR: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end
`endif
                default: begin
                    ack   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_ram_ctrl.sv
// tb_wb_ram_ctrl: randomized Wishbone traffic against a word-array reference memory.
module tb_wb_ram_ctrl;
    localparam int depth = 256;
    localparam int aw = 32;
    localparam int lw = $clog2(depth);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b1;
    always #5 clk = ~clk;

    wb_ram_ctrl_if #(.aw(aw)) wb();
    logic [3:0]    ram_we;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;
    logic [lw-1:0] ram_waddr;
    logic [lw-1:0] ram_raddr;

    wb_ram_ctrl #(.depth(depth), .aw(aw)) dut (
        .clk(clk), .rst_n(rst_n), .wb(wb),
        .ram_we(ram_we), .ram_din(ram_din), .ram_waddr(ram_waddr),
        .ram_raddr(ram_raddr), .ram_dout(ram_dout)
    );

    logic [31:0] ram [depth];
    logic [31:0] exp_mem [depth];
    int n_chk = 0;
    int n_fail = 0;

    // RAM macro model: byte-write, registered read
    always @(posedge clk) begin
        if (load)
            for (int i = 0; i < depth; i++) ram[i] <= exp_mem[i];
        else
            for (int b = 0; b < 4; b++) if (ram_we[b]) ram[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= ram[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nxt(input int w, input logic [1:0] bte);
        int len;
        len = bte == 2'd1 ? 4 : bte == 2'd2 ? 8 : bte == 2'd3 ? 16 : depth;
        return w - w % len + (w + 1) % len;
    endfunction

    task automatic upd(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) exp_mem[w][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic idle_bus();
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        wb.wb_sel_i = 4'h0;
        wb.wb_cti_i = 3'b000;
        wb.wb_bte_i = 2'b00;
    endtask

    task automatic drive(input logic [aw-1:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w, input logic [2:0] cti, input logic [1:0] bte, input logic c);
        wb.wb_adr_i = a;
        wb.wb_dat_i = d;
        wb.wb_sel_i = s;
        wb.wb_we_i  = w;
        wb.wb_cti_i = cti;
        wb.wb_bte_i = bte;
        wb.wb_cyc_i = c;
        wb.wb_stb_i = 1'b1;
    endtask

    task automatic classic(input int wd, input logic [31:0] d, input logic [3:0] s, input logic w);
        drive(aw'(wd * 4), d, s, w, 3'b000, 2'b00, 1'b1);
        @(posedge clk); #1;
        chk("cl_ack", wb.wb_ack_o, 1);
        chk("cl_err", wb.wb_err_o, 0);
        if (w) begin
            chk("cl_we", ram_we, s);
            upd(wd, d, s);
        end else begin
            chk("cl_rd", wb.wb_dat_o, exp_mem[wd]);
        end
        @(posedge clk); #1;
        idle_bus();
        #1;
        chk("cl_ack_off", wb.wb_ack_o, 0);
    endtask

    task automatic burst(input int start, input int n, input logic [1:0] bte, input logic w,
                         input int abort_at, input int rst_at);
        int wd;
        logic [31:0] d;
        logic [3:0] s;
        wd = start;
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        drive(aw'(wd * 4), d, s, w, n == 1 ? 3'b111 : 3'b010, bte, 1'b1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i > 0) begin
                wd = nxt(wd, bte);
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                drive(aw'(wd * 4), d, s, w, i == n - 1 ? 3'b111 : 3'b010, bte, i != abort_at);
            end
            if (i == rst_at) rst_n = 1'b0;
            #1;
            if (i == rst_at) begin
                chk("rst_ack", wb.wb_ack_o, 0);
                chk("rst_err", wb.wb_err_o, 0);
                chk("rst_we", ram_we, 0);
                break;
            end
            if (i == abort_at) begin
                chk("abort_we", ram_we, 0);
                break;
            end
            chk("bu_ack", wb.wb_ack_o, 1);
            if (w) begin
                chk("bu_we", ram_we, s);
                upd(wd, d, s);
            end else begin
                chk("bu_rd", wb.wb_dat_o, exp_mem[wd]);
            end
        end
        @(posedge clk); #1;
        idle_bus();
        rst_n = 1'b1;
        #1;
        chk("bu_ack_off", wb.wb_ack_o, 0);
        chk("bu_we_off", ram_we, 0);
    endtask

    initial begin
        for (int i = 0; i < depth; i++) exp_mem[i] = $urandom;
        wb.wb_adr_i = '0;
        wb.wb_dat_i = '0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack0", wb.wb_ack_o, 0);
        chk("rst_err0", wb.wb_err_o, 0);
        chk("rst_we0", ram_we, 0);
        load = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        classic(4, 32'hA5A5_1234, 4'b1111, 1'b1);
        classic(4, 32'h0, 4'b0000, 1'b0);
        classic(4, 32'hFFFF_FFFF, 4'b0100, 1'b1);
        classic(4, 32'h0, 4'b0000, 1'b0);

        burst(8, 4, 2'b00, 1'b0, -1, -1);
        burst(6, 4, 2'b01, 1'b0, -1, -1);
        burst(13, 8, 2'b10, 1'b0, -1, -1);

        drive(aw'(32'h400), 32'h0, 4'hF, 1'b0, 3'b000, 2'b00, 1'b1);
        @(posedge clk); #1;
`ifdef WB_RAM_CTRL_RANGE_CHECK_EN
        chk("oor_err", wb.wb_err_o, 1);
        chk("oor_ack", wb.wb_ack_o, 0);
        @(posedge clk); #1;
        chk("oor_err_off", wb.wb_err_o, 0);
        chk("oor_ack_off", wb.wb_ack_o, 0);
        drive(aw'(32'h404), 32'hDEAD_BEEF, 4'hF, 1'b1, 3'b000, 2'b00, 1'b1);
        @(posedge clk); #1;
        chk("oor_wr_err", wb.wb_err_o, 1);
        chk("oor_wr_we", ram_we, 0);
        @(posedge clk); #1;
`else
        chk("alias_ack", wb.wb_ack_o, 1);
        chk("alias_rd", wb.wb_dat_o, exp_mem[0]);
        @(posedge clk); #1;
`endif
        idle_bus();
        @(posedge clk); #1;

        burst(20, 4, 2'b00, 1'b1, 1, -1);
        classic(20, 32'h0, 4'h0, 1'b0);
        classic(21, 32'h0, 4'h0, 1'b0);

        burst(40, 4, 2'b00, 1'b1, -1, 1);
        classic(40, 32'h0, 4'h0, 1'b0);
        classic(41, 32'h0, 4'h0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                classic($urandom_range(0, depth - 1), $urandom, 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)));
            end else begin
                logic [1:0] bte;
                int len;
                bte = 2'($urandom_range(0, 3));
                len = bte == 2'd0 ? 4 : bte == 2'd1 ? 4 : bte == 2'd2 ? 8 : 16;
                burst($urandom_range(0, depth - 5), $urandom_range(1, len), bte,
                      1'($urandom_range(0, 1)), -1, -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_ram_ctrl.md
Name: wb_ram_ctrl

Overview:
- Wishbone B3 slave front-end; the responder side that drives a generic 32-bit byte-write synchronous RAM.
- RAM contract: 1-cycle registered read, raddr and waddr independent.
- Converts classic and incrementing-burst bus cycles into RAM write enables and read addresses.
- Returns ack/err with data aligned to the RAM read latency. Sits between the system bus interconnect and the RAM macro.

Parameters:
- depth, 256, RAM size in 32-bit words; power of two, >=16.
- aw, 32, Wishbone byte-address width.

Ports:
- clk  input  1  single clock for bus and RAM
- rst_n  input  1  asynchronous active-low reset
- wb_adr_i  input  aw  byte address; word index = wb_adr_i[$clog2(depth)+1:2]
- wb_dat_i  input  32  write data
- wb_sel_i  input  4  byte selects
- wb_we_i  input  1  write strobe
- wb_cyc_i  input  1  cycle valid
- wb_stb_i  input  1  strobe
- wb_cti_i  input  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
- wb_bte_i  input  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- wb_dat_o  output  32  read data
- wb_ack_o  output  1  transfer acknowledge
- wb_err_o  output  1  error acknowledge
- ram_we  output  4  per-byte RAM write enable
- ram_din  output  32  RAM write data (= wb_dat_i)
- ram_waddr  output  $clog2(depth)  RAM write word address
- ram_raddr  output  $clog2(depth)  RAM read word address
- ram_dout  input  32  RAM read data, valid 1 cycle after ram_raddr

Behaviour:
Reset:
- State goes to IDLE asynchronously.
- wb_ack_o=0, wb_err_o=0.
- ram_we=0, because it is gated by ack.

FSM states IDLE, SINGLE, BURST, ERR; ack and err are registered.
- IDLE:
  - ram_raddr = word(wb_adr_i), combinational.
  - On cyc&stb with an in-range address: ack<=1; go to BURST if cti==010, else SINGLE.
  - On an out-of-range address: err<=1, go to ERR.
- SINGLE: ack high for this cycle only. Next edge: ack<=0, go to IDLE. A classic transfer therefore takes 2 cycles, and back-to-back classic transfers ack on alternate cycles.
- BURST:
  - ack high.
  - ram_raddr = next(word(wb_adr_i)) so the following beat's data is ready at the next edge.
  - If cti==111, or cyc or stb is low, or the next address crosses the range limit: ack<=0, go to IDLE.
  - Otherwise ack stays 1, giving one beat per cycle.
- ERR: err high for one cycle, then go to IDLE. No RAM write occurs.

Address rules:
- next() increments the word address by 1.
- Wrap modes hold the upper bits and increment only the low 2, 3 or 4 bits (wrap4, wrap8, wrap16).
- Linear increments the full index modulo depth.
- The master must present addresses consistent with cti/bte. Non-sequential addresses inside a burst are a protocol violation; returned data in that case is undefined.

Writes:
- ram_we = wb_sel_i & {4{wb_ack_o & wb_cyc_i & wb_stb_i & wb_we_i}}.
- ram_waddr = word(wb_adr_i); ram_din = wb_dat_i.
- Exactly one write per ack. sel=0000 acks with no write.

Reads:
- wb_dat_o = ram_dout, passed through; valid only while ack is high.

Master abort:
- If cyc drops while ack is high, no write occurs that cycle.
- The FSM returns to IDLE at the next edge.

Reset asserted mid-burst:
- ack drops immediately.
- No further writes occur.

Optional Feature:
Macro WB_RAM_CTRL_RANGE_CHECK_EN.
- Defined:
  - Any nonzero bit in wb_adr_i[aw-1:$clog2(depth)+2] is out of range.
  - An out-of-range address produces one wb_err_o pulse, no ack, and no write.
  - A burst whose next() would leave range terminates with ack low.
- Not defined:
  - Upper address bits are ignored and memory aliases.
  - wb_err_o is tied 0 and the ERR state is absent.

Test Plan:
- Classic write: adr=0x10, dat=0xA5A5_1234, sel=1111, cti=000 -> ack 1 cycle after stb; ram_we=1111 in the ack cycle. Then a classic read of 0x10 -> ack next cycle, wb_dat_o=0xA5A5_1234.
- Byte write: adr=0x10, dat=0xFFFF_FFFF, sel=0100 -> read returns 0xA5FF_1234.
- Linear burst read of 4 beats from word 8 (cti 010,010,010,111) -> ack high 4 consecutive cycles; data = mem[8..11]; ack low after the 111 beat.
- Wrap4 burst read starting at word 6 -> beats return words 6, 7, 4, 5.
- Out-of-range read:
  - Macro defined, depth=256, adr=0x400 -> err for 1 cycle, no ack.
  - Macro undefined, same access -> ack with data aliased to word 0.
- Abort and reset:
  - Burst write with cyc dropped on beat 2 -> only beat 1 written; ack low the next cycle.
  - rst_n low mid-burst -> ack/err 0 asynchronously; no ram_we.
